mul_hilo_unit: RTL and testbench
================================

MUL_HILO_UNIT -- requirements
Module: mul_hilo_unit

Interface
REQ-001 Parameter: MUL_LAT, default 4, multiplier latency in clock cycles from operand issue to product valid; legal range 1..8.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 issue_valid  input  1  a multiply was issued to the upstream multiplier this cycle.
REQ-005 issue_op  input  2  operation tag: 00 MULT, 01 MADD, 10 MSUB, 11 reserved (treated as no-op, still tracked).
REQ-006 product  input  64  multiplier output; valid exactly MUL_LAT cycles after the matching issue.
REQ-007 mthi_en / mtlo_en  input  1 each  write wdata into HI / LO.
REQ-008 wdata  input  32  move-to data.
REQ-009 mf_req  input  1  read request for HI/LO; mf_sel input 1 selects it (0 LO, 1 HI).
REQ-010 mf_data  output  32  selected register value.
REQ-011 stall  output  1  processor must hold the current mf/mt request.
REQ-012 busy  output  1  at least one multiply in flight.
REQ-013 hi / lo  output  32 each  architectural HI/LO registers.

Function
REQ-014 Op-tag shift pipeline of MUL_LAT stages (valid bit + 2-bit op) advances every cycle; stage 0 loads {issue_valid, issue_op}.
REQ-015 Commit occurs when the last stage is valid: MULT {hi,lo}<=product; MADD {hi,lo}<={hi,lo}+product; MSUB {hi,lo}<={hi,lo}-product; reserved no change.
REQ-016 Arithmetic is 64-bit modulo 2^64; carry/borrow out discarded, no flags.
REQ-017 Back-to-back issues on consecutive cycles are accepted; each commits in its own cycle, in issue order, using the result of the previous commit.
REQ-018 In-flight counter increments on issue, decrements on commit, both in one cycle = unchanged; width holds 0..MUL_LAT; busy = (count != 0).
REQ-019 stall = (mf_req | mthi_en | mtlo_en) & busy; combinational.
REQ-020 issue_valid is accepted even while stall is high.
REQ-021 Unstalled mt writes update HI/LO at the clock edge; mthi_en and mtlo_en together update both.
REQ-022 mf_data = mf_sel ? hi : lo, combinational from registered values; value meaningful only when stall is low.
REQ-023 Stalled mt writes are not applied; commit always has priority, so no mt/commit conflict can occur.

Reset
REQ-024 While reset is high: hi=0, lo=0, all tag valids=0, count=0, busy=0, stall=0 (in-flight ops discarded).
REQ-025 Reset asserted mid-operation discards every pending commit; products arriving after release are ignored unless matched by a post-reset issue.

Configuration
REQ-026 Macro MUL_HILO_FWD_EN.
REQ-027 Defined: when count==1 and the committing op is in the last stage this cycle, stall is not raised for mf_req; mf_data returns the commit result half selected by mf_sel; mt requests still stall.
REQ-028 Undefined: REQ-019 applies unmodified; mf_req waits one extra cycle after the final commit.

Verification (MUL_LAT=4)
REQ-029 MULT 11111x11111 issued at cycle 0, product 123454321 at cycle 4 -> lo=123454321, hi=0 after cycle-4 edge; busy high cycles 1-4.
REQ-030 MULT 10x40 then MADD 10x50 on consecutive cycles -> lo=400 after first commit, lo=900 after second; count peaks at 2.
REQ-031 From reset, MSUB product=100 -> hi=FFFFFFFF, lo=FFFFFF9C.
REQ-032 mf_req, mf_sel=0 one cycle after MULT 10x20 -> stall high until commit (until cycle after commit without MUL_HILO_FWD_EN); then mf_data=200.
REQ-033 MULT issued, reset pulsed at cycle 2, product presented at cycle 4 -> hi=lo=0, busy=0 throughout.
REQ-034 mtlo_en wdata=0x1234 while busy -> stall high, lo unchanged; after drain, write applied, lo=0x1234.

Source files
------------

// File: rtl/mul_hilo_unit.sv
// mul_hilo_unit
//   Tracks multiplies issued to an external fixed-latency multiplier and
//   commits each returning product into the architectural HI/LO pair.
//   Operations are MULT (overwrite), MADD (accumulate) and MSUB (subtract).
//   The unit also arbitrates processor move-to/move-from accesses of HI/LO.
//   Any such access is stalled while a multiply is still in flight.
//
// Parameters
//   MUL_LAT        multiplier latency in cycles from issue to product (1..8)
//
// Build option
//   MUL_HILO_FWD_EN  When defined, a move-from request made in the cycle of
//                    the final outstanding commit is not stalled. The result
//                    being committed in that cycle is forwarded to the reader.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_issue_valid  a multiply was issued upstream this cycle
//   i_issue_op     00 MULT, 01 MADD, 10 MSUB, 11 reserved (no-op, tracked)
//   i_product      multiplier output, valid MUL_LAT cycles after its issue
//   i_mthi_en      write i_wdata into HI
//   i_mtlo_en      write i_wdata into LO
//   i_wdata        move-to data
//   i_mf_req       move-from request
//   i_mf_sel       move-from select (0 LO, 1 HI)
//   o_mf_data      selected register value (meaningful when o_stall is low)
//   o_stall        processor must hold its current mf/mt request
//   o_busy         at least one multiply in flight
//   o_hi, o_lo     architectural HI/LO registers
//
// Handshake: an mf/mt request is taken in any cycle where o_stall is low.
// A request seen while o_stall is high has no effect. The processor keeps
// the request asserted until it sees o_stall low. Issues are never
// back-pressured.
module mul_hilo_unit #(
  parameter int MUL_LAT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_issue_valid,
  input  logic [1:0]  i_issue_op,
  input  logic [63:0] i_product,
  input  logic        i_mthi_en,
  input  logic        i_mtlo_en,
  input  logic [31:0] i_wdata,
  input  logic        i_mf_req,
  input  logic        i_mf_sel,
  output logic [31:0] o_mf_data,
  output logic        o_stall,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int LAST = MUL_LAT - 1;
  localparam int CW   = $clog2(MUL_LAT + 1);

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_MADD = 2'b01;
  localparam logic [1:0] OP_MSUB = 2'b10;

  logic [MUL_LAT-1:0] r_vld;
  logic [1:0]         r_op [MUL_LAT];
  logic [CW-1:0]      r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic               w_commit;
  logic               w_busy;
  logic               w_mt;
  logic [63:0]        w_acc;
  logic [63:0]        w_res;

  assign w_commit = r_vld[LAST];
  assign w_busy   = (r_cnt != '0);
  assign w_mt     = i_mthi_en | i_mtlo_en;
  assign w_acc    = {r_hi, r_lo};

  // Commit result. The arithmetic wraps modulo 2^64, so any carry or
  // borrow out of the top bit is dropped.
  always_comb begin
    w_res = w_acc;
    case (r_op[LAST])
      OP_MULT: w_res = i_product;
      OP_MADD: w_res = w_acc + i_product;
      OP_MSUB: w_res = w_acc - i_product;
      default: w_res = w_acc;
    endcase
  end

  // Op-tag pipeline. The tag reaches the last stage in the same cycle
  // that its product appears.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
      for (int i = 0; i < MUL_LAT; i++) r_op[i] <= 2'b00;
    end else begin
      r_vld[0] <= i_issue_valid;
      r_op[0]  <= i_issue_op;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_op[i]  <= r_op[i-1];
      end
    end
  end

  // In-flight counter. An issue and a commit in the same cycle cancel out.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      case ({i_issue_valid, w_commit})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // HI/LO update. A commit implies busy, so it never coincides with an
  // accepted move-to; the commit still takes priority explicitly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= w_res[63:32];
      r_lo <= w_res[31:0];
    end else if (!w_busy) begin
      if (i_mthi_en) r_hi <= i_wdata;
      if (i_mtlo_en) r_lo <= i_wdata;
    end
  end

`ifdef MUL_HILO_FWD_EN
  // Forward only when the committing op is the last one outstanding. In
  // that case HI/LO is final at the end of this cycle.
  logic w_fwd;
  assign w_fwd     = w_commit && (r_cnt == CW'(1));
  assign o_stall   = (w_mt & w_busy) | (i_mf_req & w_busy & ~w_fwd);
  assign o_mf_data = w_fwd ? (i_mf_sel ? w_res[63:32] : w_res[31:0])
                           : (i_mf_sel ? r_hi : r_lo);
`else
  assign o_stall   = (i_mf_req | w_mt) & w_busy;
  assign o_mf_data = i_mf_sel ? r_hi : r_lo;
`endif

  assign o_busy = w_busy;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Directed bench for mul_hilo_unit at MUL_LAT = 4.
// Cycle k is the interval after k clock edges have passed since the issue.
// Inputs are driven, and outputs sampled, 1 ns after the rising edge.
// The product bus carries junk except in the one cycle it is meant to be
// valid.
module tb_mul_hilo_unit;

  localparam logic [63:0] JUNK = 64'hA5A5_A5A5_5A5A_5A5A;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_issue_valid;
  logic [1:0]  i_issue_op;
  logic [63:0] i_product;
  logic        i_mthi_en;
  logic        i_mtlo_en;
  logic [31:0] i_wdata;
  logic        i_mf_req;
  logic        i_mf_sel;
  logic [31:0] o_mf_data;
  logic        o_stall;
  logic        o_busy;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int n_chk = 0;
  int n_err = 0;

  mul_hilo_unit #(.MUL_LAT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_issue_valid(i_issue_valid),
    .i_issue_op(i_issue_op), .i_product(i_product), .i_mthi_en(i_mthi_en),
    .i_mtlo_en(i_mtlo_en), .i_wdata(i_wdata), .i_mf_req(i_mf_req),
    .i_mf_sel(i_mf_sel), .o_mf_data(o_mf_data), .o_stall(o_stall),
    .o_busy(o_busy), .o_hi(o_hi), .o_lo(o_lo)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_issue_valid = 1'b0;
    i_issue_op    = 2'b00;
    i_product     = JUNK;
    i_mthi_en     = 1'b0;
    i_mtlo_en     = 1'b0;
    i_wdata       = 32'h0;
    i_mf_req      = 1'b0;
    i_mf_sel      = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  // Issue at cycle 0, product driven in cycle 4, ends in cycle 5.
  task automatic single_op(input logic [1:0] op, input logic [63:0] prod);
    i_issue_valid = 1'b1;
    i_issue_op    = op;
    tick();
    i_issue_valid = 1'b0;
    tick();
    tick();
    tick();
    i_product = prod;
    tick();
    i_product = JUNK;
  endtask

  initial begin
    idle();
    i_rst = 1'b1;
    i_mf_req = 1'b1;
    #3;
    chk("rst_hi", {32'h0, o_hi}, 64'h0);
    chk("rst_lo", {32'h0, o_lo}, 64'h0);
    chk("rst_busy", {63'h0, o_busy}, 64'h0);
    chk("rst_stall", {63'h0, o_stall}, 64'h0);
    i_mf_req = 1'b0;
    tick();
    i_rst = 1'b0;
    tick();

    // MULT 11111 x 11111: busy during cycles 1-4, commit on the cycle-4 edge
    i_issue_valid = 1'b1; i_issue_op = 2'b00;
    tick();
    i_issue_valid = 1'b0;
    chk("t1_busy_c1", {63'h0, o_busy}, 64'h1);
    tick(); tick();
    chk("t1_lo_c3", {32'h0, o_lo}, 64'h0);
    tick();
    i_product = 64'd123454321;
    chk("t1_busy_c4", {63'h0, o_busy}, 64'h1);
    tick();
    i_product = JUNK;
    chk("t1_lo", {32'h0, o_lo}, 64'd123454321);
    chk("t1_hi", {32'h0, o_hi}, 64'h0);
    chk("t1_busy_c5", {63'h0, o_busy}, 64'h0);

    // MULT 400, MADD 500 back-to-back; a third MULT issued on the first
    // commit cycle keeps the count steady.
    i_issue_valid = 1'b1; i_issue_op = 2'b00;            // cycle 0
    tick();
    i_issue_op = 2'b01;                                  // cycle 1
    tick();
    i_issue_valid = 1'b0;                                // cycle 2
    tick(); tick();
    i_issue_valid = 1'b1; i_issue_op = 2'b00;            // cycle 4
    i_product = 64'd400;
    tick();
    i_issue_valid = 1'b0;                                // cycle 5
    i_product = 64'd500;
    chk("t2_lo_first", {32'h0, o_lo}, 64'd400);
    tick();
    i_product = JUNK;                                    // cycle 6
    chk("t2_lo_second", {32'h0, o_lo}, 64'd900);
    chk("t2_hi_second", {32'h0, o_hi}, 64'h0);
    chk("t2_busy_c6", {63'h0, o_busy}, 64'h1);
    tick();
    chk("t2_busy_c7", {63'h0, o_busy}, 64'h1);
    tick();
    i_product = 64'd7;                                   // cycle 8
    tick();
    i_product = JUNK;                                    // cycle 9
    chk("t2_lo_third", {32'h0, o_lo}, 64'd7);
    chk("t2_busy_c9", {63'h0, o_busy}, 64'h0);

    // MSUB 100 from reset wraps through zero
    do_reset();
    single_op(2'b10, 64'd100);
    chk("t3_hi", {32'h0, o_hi}, 64'hFFFF_FFFF);
    chk("t3_lo", {32'h0, o_lo}, 64'hFFFF_FF9C);
    i_mf_req = 1'b1; i_mf_sel = 1'b1;
    #1;
    chk("t3_mf_hi", {32'h0, o_mf_data}, 64'hFFFF_FFFF);
    chk("t3_stall_idle", {63'h0, o_stall}, 64'h0);
    i_mf_sel = 1'b0;
    #1;
    chk("t3_mf_lo", {32'h0, o_mf_data}, 64'hFFFF_FF9C);
    i_mf_req = 1'b0;
    tick();

    // MADD 0x65 onto FFFFFFFF_FFFFFF9C: carry crosses into HI, top carry dropped
    single_op(2'b01, 64'h65);
    chk("t4_hi", {32'h0, o_hi}, 64'h0);
    chk("t4_lo", {32'h0, o_lo}, 64'h1);

    // Reserved op: tracked (busy) but leaves HI/LO alone
    i_issue_valid = 1'b1; i_issue_op = 2'b11;
    tick();
    i_issue_valid = 1'b0;
    chk("t5_busy", {63'h0, o_busy}, 64'h1);
    tick(); tick(); tick();
    i_product = 64'h1234_5678_9ABC_DEF0;
    tick();
    i_product = JUNK;
    chk("t5_lo", {32'h0, o_lo}, 64'h1);
    chk("t5_hi", {32'h0, o_hi}, 64'h0);
    chk("t5_busy_after", {63'h0, o_busy}, 64'h0);

    // MULT 10x20 with an mf_req for LO starting in cycle 1
    i_issue_valid = 1'b1; i_issue_op = 2'b00;
    tick();
    i_issue_valid = 1'b0;
    i_mf_req = 1'b1; i_mf_sel = 1'b0;
    #1;
    chk("t6_stall_c1", {63'h0, o_stall}, 64'h1);
    tick(); tick();
    chk("t6_stall_c3", {63'h0, o_stall}, 64'h1);
    tick();
    i_product = 64'd200;
    #1;
`ifdef MUL_HILO_FWD_EN
    chk("t6_stall_c4", {63'h0, o_stall}, 64'h0);
    chk("t6_fwd_data", {32'h0, o_mf_data}, 64'd200);
`else
    chk("t6_stall_c4", {63'h0, o_stall}, 64'h1);
`endif
    tick();
    i_product = JUNK;
    chk("t6_stall_c5", {63'h0, o_stall}, 64'h0);
    chk("t6_mf_data", {32'h0, o_mf_data}, 64'd200);
    i_mf_req = 1'b0;

    // mtlo while busy is held off; the commit lands first, then the write
    i_issue_valid = 1'b1; i_issue_op = 2'b00;
    tick();
    i_issue_valid = 1'b0;
    i_mtlo_en = 1'b1; i_wdata = 32'h1234;
    tick();
    chk("t7_stall_c2", {63'h0, o_stall}, 64'h1);
    chk("t7_lo_c2", {32'h0, o_lo}, 64'd200);
    tick(); tick();
    i_product = 64'h77;
    #1;
    chk("t7_stall_c4", {63'h0, o_stall}, 64'h1);
    tick();
    i_product = JUNK;
    chk("t7_lo_commit", {32'h0, o_lo}, 64'h77);
    chk("t7_stall_c5", {63'h0, o_stall}, 64'h0);
    tick();
    chk("t7_lo_written", {32'h0, o_lo}, 64'h1234);
    chk("t7_hi_kept", {32'h0, o_hi}, 64'h0);
    i_mtlo_en = 1'b0;
    i_mthi_en = 1'b1; i_wdata = 32'hCAFE_0001;
    tick();
    chk("t7_mthi", {32'h0, o_hi}, 64'hCAFE_0001);
    chk("t7_lo_after_mthi", {32'h0, o_lo}, 64'h1234);
    i_mtlo_en = 1'b1; i_wdata = 32'hCAFE_BABE;
    tick();
    i_mthi_en = 1'b0; i_mtlo_en = 1'b0;
    chk("t7_both_hi", {32'h0, o_hi}, 64'hCAFE_BABE);
    chk("t7_both_lo", {32'h0, o_lo}, 64'hCAFE_BABE);

    // Reset pulsed mid-flight discards the pending commit
    i_issue_valid = 1'b1; i_issue_op = 2'b00;
    tick();
    i_issue_valid = 1'b0;
    chk("t8_busy_c1", {63'h0, o_busy}, 64'h1);
    tick();
    i_rst = 1'b1; i_mf_req = 1'b1;                       // cycle 2
    #1;
    chk("t8_rst_busy", {63'h0, o_busy}, 64'h0);
    chk("t8_rst_stall", {63'h0, o_stall}, 64'h0);
    chk("t8_rst_lo", {32'h0, o_lo}, 64'h0);
    tick();
    i_rst = 1'b0; i_mf_req = 1'b0;                       // cycle 3
    tick();
    i_product = 64'd999;                                 // cycle 4
    chk("t8_busy_c4", {63'h0, o_busy}, 64'h0);
    tick();
    i_product = JUNK;
    chk("t8_lo", {32'h0, o_lo}, 64'h0);
    chk("t8_hi", {32'h0, o_hi}, 64'h0);
    chk("t8_busy_c5", {63'h0, o_busy}, 64'h0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
